// File: rtl/decode_stage_pipe_pkg.sv
// LC-3b decode types: control word, ID/EX bundle, opcode decoder and source-usage helpers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    localparam lc3b_reg LC3B_LINK_REG = 3'd7;

    typedef enum logic [3:0] {
        OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
        OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
        OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'ha, OP_STI  = 4'hb,
        OP_JMP = 4'hc, OP_SHF = 4'hd, OP_LEA = 4'he, OP_TRAP = 4'hf
    } lc3b_opcode;

    typedef enum logic [2:0] {
        ALUMUX_ZERO, ALUMUX_ADJ6, ALUMUX_SEXT5, ALUMUX_SEXT6, ALUMUX_ZEXT4
    } lc3b_alumux_sel;

    typedef struct packed {
        lc3b_opcode     opcode;
        lc3b_alumux_sel alumux_sel;
        logic           adjmux_sel;    // 0: adj9, 1: adj11
        logic           storemux_sel;  // store data comes from IR[11:9]
        logic           load_regfile;
        logic           load_cc;
        logic           mem_read;
        logic           mem_write;
        logic           mem_byte;
        logic           indirect;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_control_word ctrl;
        lc3b_word         pc;
        lc3b_word         sr1;
        lc3b_word         sr2;
        lc3b_word         imm;
        lc3b_word         adj;
        lc3b_word         trap;
        lc3b_reg          dest;
    } decode_ex_bundle;

    // JSR is listed because JSRR reads BaseR; the caller masks it by IR[11].
    function automatic logic uses_sr1(lc3b_opcode op);
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LDB, OP_LDR, OP_LDI,
            OP_STB, OP_STR, OP_STI, OP_JMP, OP_SHF, OP_JSR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ADD/AND only read SR2 in register mode; the caller masks it by IR[5].
    function automatic logic uses_sr2(lc3b_opcode op);
        case (op)
            OP_ADD, OP_AND, OP_STB, OP_STR, OP_STI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic lc3b_control_word decode_ctrl(lc3b_word ir);
        lc3b_control_word c;
        c        = '0;
        c.opcode = lc3b_opcode'(ir[15:12]);
        case (c.opcode)
            OP_ADD, OP_AND: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
                c.alumux_sel   = ir[5] ? ALUMUX_SEXT5 : ALUMUX_ZERO;
            end
            OP_NOT: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
            end
            OP_SHF: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
                c.alumux_sel   = ALUMUX_ZEXT4;
            end
            OP_LDB: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
                c.mem_read     = 1'b1;
                c.mem_byte     = 1'b1;
                c.alumux_sel   = ALUMUX_SEXT6;
            end
            OP_LDR, OP_LDI: begin
                c.load_regfile = 1'b1;
                c.load_cc      = 1'b1;
                c.mem_read     = 1'b1;
                c.indirect     = (c.opcode == OP_LDI);
                c.alumux_sel   = ALUMUX_ADJ6;
            end
            OP_STB: begin
                c.storemux_sel = 1'b1;
                c.mem_write    = 1'b1;
                c.mem_byte     = 1'b1;
                c.alumux_sel   = ALUMUX_SEXT6;
            end
            OP_STR, OP_STI: begin
                c.storemux_sel = 1'b1;
                c.mem_write    = 1'b1;
                c.indirect     = (c.opcode == OP_STI);
                c.alumux_sel   = ALUMUX_ADJ6;
            end
            OP_LEA:  c.load_regfile = 1'b1;
            OP_JSR: begin
                c.load_regfile = 1'b1;
                c.adjmux_sel   = 1'b1;
            end
            OP_TRAP: c.load_regfile = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-stage port bundle: IF/ID input handshake, ID/EX output handshake, flush and write-back.
interface decode_stage_pipe_if #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
);
    import lc3b_types::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_instr;
    logic [WIDTH-1:0]       in_pc;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    lc3b_control_word       out_ctrl;
    logic [WIDTH-1:0]       out_pc;
    logic [WIDTH-1:0]       out_sr1;
    logic [WIDTH-1:0]       out_sr2;
    logic [WIDTH-1:0]       out_imm;
    logic [WIDTH-1:0]       out_adj;
    logic [WIDTH-1:0]       out_trap;
    logic [RW-1:0]          out_dest;
    logic                   wb_valid;
    logic                   wb_we;
    logic [RW-1:0]          wb_dest;
    logic [WIDTH-1:0]       wb_data;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
               wb_valid, wb_we, wb_dest, wb_data,
        input  in_ready, out_valid, out_ctrl, out_pc, out_sr1, out_sr2,
               out_imm, out_adj, out_trap, out_dest
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
               wb_valid, wb_we, wb_dest, wb_data,
        output in_ready, out_valid, out_ctrl, out_pc, out_sr1, out_sr2,
               out_imm, out_adj, out_trap, out_dest
    );

endinterface

// File: rtl/decode_stage_pipe_scoreboard.sv
// Per-register in-flight write counters: issue increments, retire and flush-kill decrement (netted).
module decode_scoreboard #(
    parameter int  NREGS = 8,
    parameter int  CNT_W = 2,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue,
    input  logic [RW-1:0]                issue_reg,
    input  logic                         retire,
    input  logic [RW-1:0]                retire_reg,
    input  logic                         kill,
    input  logic [RW-1:0]                kill_reg,
    output logic [NREGS-1:0][CNT_W-1:0]  cnt,
    output logic [NREGS-1:0]             pending
);

    logic [NREGS-1:0][CNT_W:0] up;
    logic [NREGS-1:0][1:0]     dn;
    logic [NREGS-1:0]          underflow;

    always_comb begin
        up        = '0;
        dn        = '0;
        underflow = '0;
        pending   = '0;
        for (int i = 0; i < NREGS; i++) begin
            up[i]        = {1'b0, cnt[i]} + (CNT_W+1)'(issue && issue_reg == RW'(i));
            dn[i]        = 2'(retire && retire_reg == RW'(i)) + 2'(kill && kill_reg == RW'(i));
            underflow[i] = up[i] < (CNT_W+1)'(dn[i]);
            pending[i]   = cnt[i] != '0;
        end
    end

    // Over-retiring is a protocol error upstream; the counter floors at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= underflow[i] ? '0 : CNT_W'(up[i] - (CNT_W+1)'(dn[i]));
            assert (underflow == '0);
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// LC-3b decode stage with registered ID/EX bundle, regfile and RAW/WAW scoreboard.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle write-back into the operands instead of stalling.
module decode_stage_pipe
    import lc3b_types::*;
#(
    parameter int  WIDTH = 16,
    parameter int  NREGS = 8,
    parameter int  CNT_W = 2,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    decode_stage_pipe_if.slave  bus
);

    lc3b_word                    ir;
    lc3b_control_word            ctrl;
    lc3b_opcode                  op;
    lc3b_reg                     sr1, sr2, dest;
    logic                        sr1_used, sr2_used;
    logic                        fwd1, fwd2;
    logic                        hazard, accept, kill;
    logic [NREGS-1:0][CNT_W-1:0] sb_cnt;
    logic [NREGS-1:0]            sb_pending;
    lc3b_word                    regs [NREGS];
    decode_ex_bundle             nxt, out_q;
    logic                        out_vld;

    assign ir   = lc3b_word'(bus.in_instr);
    assign ctrl = decode_ctrl(ir);
    assign op   = ctrl.opcode;
    assign sr1  = ir[8:6];
    assign sr2  = ctrl.storemux_sel ? ir[11:9] : ir[2:0];
    assign dest = (op == OP_JSR || op == OP_TRAP) ? LC3B_LINK_REG : ir[11:9];

    assign sr1_used = uses_sr1(op) && !(op == OP_JSR && ir[11]);
    assign sr2_used = uses_sr2(op) && !((op == OP_ADD || op == OP_AND) && ir[5]);

`ifdef DECODE_WB_BYPASS_EN
    // Only the last outstanding write may be forwarded; older ones would leave a stale winner.
    logic wb_write;
    assign wb_write = bus.wb_valid && bus.wb_we;
    assign fwd1 = wb_write && bus.wb_dest == sr1 && sb_cnt[sr1] == CNT_W'(1);
    assign fwd2 = wb_write && bus.wb_dest == sr2 && sb_cnt[sr2] == CNT_W'(1);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign hazard = (sr1_used && sb_pending[sr1] && !fwd1)
                 || (sr2_used && sb_pending[sr2] && !fwd2)
                 || (ctrl.load_regfile && sb_cnt[dest] == '1);

    assign bus.in_ready = !reset && !bus.flush && !hazard && (!out_vld || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign kill         = bus.flush && out_vld && out_q.ctrl.load_regfile;

    decode_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue      (accept && ctrl.load_regfile),
        .issue_reg  (dest),
        .retire     (bus.wb_valid),
        .retire_reg (bus.wb_dest),
        .kill       (kill),
        .kill_reg   (out_q.dest),
        .cnt        (sb_cnt),
        .pending    (sb_pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wb_valid && bus.wb_we) begin
            regs[bus.wb_dest] <= lc3b_word'(bus.wb_data);
        end
    end

    always_comb begin
        nxt      = '0;
        nxt.ctrl = ctrl;
        nxt.pc   = lc3b_word'(bus.in_pc);
        nxt.sr1  = fwd1 ? lc3b_word'(bus.wb_data) : regs[sr1];
        nxt.sr2  = fwd2 ? lc3b_word'(bus.wb_data) : regs[sr2];
        case (ctrl.alumux_sel)
            ALUMUX_ADJ6:  nxt.imm = {{9{ir[5]}}, ir[5:0], 1'b0};
            ALUMUX_SEXT5: nxt.imm = {{11{ir[4]}}, ir[4:0]};
            ALUMUX_SEXT6: nxt.imm = {{10{ir[5]}}, ir[5:0]};
            ALUMUX_ZEXT4: nxt.imm = {12'b0, ir[3:0]};
            default:      nxt.imm = '0;
        endcase
        nxt.adj  = ctrl.adjmux_sel ? {{4{ir[10]}}, ir[10:0], 1'b0}
                                   : {{6{ir[8]}}, ir[8:0], 1'b0};
        nxt.trap = {7'b0, ir[7:0], 1'b0};
        nxt.dest = dest;
    end

    // Bundle only changes on accept, so it is stable across an out_ready stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (bus.flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld <= 1'b1;
            out_q   <= nxt;
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.out_valid = out_vld;
    assign bus.out_ctrl  = out_q.ctrl;
    assign bus.out_pc    = WIDTH'(out_q.pc);
    assign bus.out_sr1   = WIDTH'(out_q.sr1);
    assign bus.out_sr2   = WIDTH'(out_q.sr2);
    assign bus.out_imm   = WIDTH'(out_q.imm);
    assign bus.out_adj   = WIDTH'(out_q.adj);
    assign bus.out_trap  = WIDTH'(out_q.trap);
    assign bus.out_dest  = RW'(out_q.dest);

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: handshake, hazards, bypass/stall, flush and reset.
module tb_decode_stage_pipe;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    decode_stage_pipe_if #(.WIDTH(16), .RW(3)) bus ();

    decode_stage_pipe #(.WIDTH(16), .NREGS(8), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] instr, input logic [15:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic wb(input logic v, input logic we, input logic [2:0] d, input logic [15:0] data);
        bus.wb_valid = v;
        bus.wb_we    = we;
        bus.wb_dest  = d;
        bus.wb_data  = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        wb(0, 0, 0, 0);
        tick; tick;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_cnt", dut.sb_cnt, 0);
        chk("rst_out_sr1", bus.out_sr1, 0);
        reset = 1'b0;

        // Seed R2=0x22, R3=0x33 through issue + write-back
        send(16'hE400, 16'h0100); #1; chk("setup_rdy", bus.in_ready, 1); tick;
        send(16'hE600, 16'h0102); tick;
        bus.in_valid = 1'b0;
        wb(1, 1, 2, 16'h0022); tick;
        wb(1, 1, 3, 16'h0033); tick;
        wb(0, 0, 0, 0);
        chk("setup_cnt", dut.sb_cnt, 0);

        // 1: ADD R1,R2,R3
        send(16'h1283, 16'h3002); #1; chk("t1_rdy", bus.in_ready, 1); tick;
        bus.in_valid = 1'b0;
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_sr1", bus.out_sr1, 16'h0022);
        chk("t1_sr2", bus.out_sr2, 16'h0033);
        chk("t1_pc", bus.out_pc, 16'h3002);
        chk("t1_dest", bus.out_dest, 1);
        chk("t1_imm", bus.out_imm, 0);
        chk("t1_cnt1", dut.sb_cnt[1], 1);

        // 2: ADD R4,R1,#1 RAW on R1
        send(16'h1861, 16'h3004); #1; chk("t2_stall", bus.in_ready, 0); tick;
        chk("t2_drain", bus.out_valid, 0);
        wb(1, 1, 1, 16'h1234); #1;
`ifdef DECODE_WB_BYPASS_EN
        chk("t2_byp_rdy", bus.in_ready, 1); tick;
`else
        chk("t2_nobyp_rdy", bus.in_ready, 0); tick;
        wb(0, 0, 0, 0); #1; chk("t2_late_rdy", bus.in_ready, 1); tick;
`endif
        bus.in_valid = 1'b0;
        wb(0, 0, 0, 0);
        chk("t2_valid", bus.out_valid, 1);
        chk("t2_sr1", bus.out_sr1, 16'h1234);
        chk("t2_imm", bus.out_imm, 16'h0001);
        chk("t2_dest", bus.out_dest, 4);
        chk("t2_cnt1", dut.sb_cnt[1], 0);
        chk("t2_cnt4", dut.sb_cnt[4], 1);
        wb(1, 1, 4, 16'h0044); tick;
        wb(0, 0, 0, 0);

        // 3: WAW saturation on R5
        send(16'hEA00, 16'h3010);
        for (int k = 0; k < 3; k++) tick;
        chk("t3_cnt5_full", dut.sb_cnt[5], 3);
        #1; chk("t3_full_stall", bus.in_ready, 0); tick;
        wb(1, 1, 5, 16'h0055); #1; chk("t3_retire_cycle_stall", bus.in_ready, 0); tick;
        wb(0, 0, 0, 0);
        chk("t3_cnt5_after_retire", dut.sb_cnt[5], 2);
        #1; chk("t3_rdy", bus.in_ready, 1); tick;
        bus.in_valid = 1'b0;
        chk("t3_cnt5_refill", dut.sb_cnt[5], 3);
        for (int k = 0; k < 3; k++) begin
            wb(1, 1, 5, 16'h0055); tick;
        end
        wb(0, 0, 0, 0);
        chk("t3_cnt5_drained", dut.sb_cnt[5], 0);

        // 4: downstream backpressure
        bus.out_ready = 1'b0;
        send(16'h1C83, 16'h4000); tick;
        send(16'h90BF, 16'h4002);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_hold_rdy", bus.in_ready, 0);
            chk("t4_hold_pc", bus.out_pc, 16'h4000);
            chk("t4_hold_valid", bus.out_valid, 1);
            tick;
        end
        bus.out_ready = 1'b1; #1; chk("t4_release_rdy", bus.in_ready, 1); tick;
        bus.in_valid = 1'b0;
        chk("t4_next_pc", bus.out_pc, 16'h4002);
        chk("t4_next_dest", bus.out_dest, 0);
        chk("t4_next_sr1", bus.out_sr1, 16'h0022);

        // Link-register destinations, trap vector, adj11
        send(16'hF025, 16'h4004); tick;
        chk("trap_vec", bus.out_trap, 16'h004A);
        chk("trap_dest", bus.out_dest, 7);
        send(16'h4802, 16'h4006); tick;
        bus.in_valid = 1'b0;
        chk("jsr_adj11", bus.out_adj, 16'h0004);
        chk("jsr_dest", bus.out_dest, 7);
        chk("jsr_cnt7", dut.sb_cnt[7], 2);
        wb(1, 1, 6, 16'h0066); tick;
        wb(1, 1, 0, 16'h00AA); tick;
        wb(1, 0, 7, 16'hDEAD); tick;
        wb(1, 0, 7, 16'hBEEF); tick;
        wb(0, 0, 0, 0);
        chk("retire_all_cnt", dut.sb_cnt, 0);
        send(16'h13C0, 16'h4008); tick;
        bus.in_valid = 1'b0;
        chk("squash_no_write_r7", bus.out_sr1, 0);
        chk("written_r0", bus.out_sr2, 16'h00AA);
        wb(1, 0, 1, 16'h0000); tick;
        wb(0, 0, 0, 0);

        // 5: flush of LDR R2 with the older R2 writer retiring in the same cycle
        send(16'hE400, 16'h5000); tick;
        send(16'h64C1, 16'h5002); tick;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_valid", bus.out_valid, 1);
        chk("t5_imm", bus.out_imm, 16'h0002);
        chk("t5_sr1", bus.out_sr1, 16'h0033);
        chk("t5_dest", bus.out_dest, 2);
        chk("t5_memread", bus.out_ctrl.mem_read, 1);
        chk("t5_cnt2", dut.sb_cnt[2], 2);
        bus.flush = 1'b1;
        wb(1, 1, 2, 16'h0222); #1; chk("t5_flush_rdy", bus.in_ready, 0); tick;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        wb(0, 0, 0, 0);
        chk("t5_killed", bus.out_valid, 0);
        chk("t5_cnt2_zero", dut.sb_cnt[2], 0);

        // 6: reset in the middle of a RAW stall
        send(16'hE600, 16'h6000); tick; tick;
        send(16'h12E0, 16'h6004); #1;
        chk("t6_stall", bus.in_ready, 0);
        chk("t6_cnt3", dut.sb_cnt[3], 2);
        reset = 1'b1; tick;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_cnt", dut.sb_cnt, 0);
        chk("t6_rst_rdy", bus.in_ready, 0);
        reset = 1'b0; #1; chk("t6_rdy", bus.in_ready, 1); tick;
        bus.in_valid = 1'b0;
        chk("t6_valid", bus.out_valid, 1);
        chk("t6_r3_cleared", bus.out_sr1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
